// File: rtl/inst_fetch_pkg.sv
// Shared MIPS32 fetch definitions: reset PC default, nop encoding,
// fetch FSM state encoding and a word-alignment helper.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Redirect targets are always word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM port.
//   imem_addr : fetch word address (driven by the fetch stage)
//   imem_inst : instruction returned combinationally for imem_addr
interface inst_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;

    modport master (output imem_addr, input imem_inst);
    modport slave  (input imem_addr, output imem_inst);
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register.
//   load_i   : capture {valid=1, inst_i, pc_i, pc4_i}
//   bubble_i : capture an all-zero invalid entry (wins over load_i)
//   neither  : hold
// Async active-low clear to the bubble value.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/inst_fetch.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the ROM address,
// fills IF/ID, applies stall/flush/branch/jump and halts on jump-to-self.
//   clk, rst_n          : clock, async active-low reset
//   imem                : ROM port (master side)
//   stall, flush        : hazard-unit controls
//   branch_taken/target : EX redirect (highest priority)
//   jump/jump_target    : ID redirect, ignored while stalled
//   ifid_*              : IF/ID register contents
//   halted              : fetch stopped on jump-to-self
//   inst_count          : valid instructions loaded into IF/ID
//
// state | meaning
// BOOT  | one cycle after reset, PC held at RESET_PC, IF/ID invalid
// RUN   | normal fetch with redirect/stall/flush handling
// HALT  | jump-to-self seen; everything frozen until reset
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_if.master       imem,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    input  logic               jump,
    input  logic [31:0]        jump_target,
    output logic               ifid_valid,
    output logic [31:0]        ifid_inst,
    output logic [31:0]        ifid_pc,
    output logic [31:0]        ifid_pc4,
    output logic               halted,
    output logic [31:0]        inst_count
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        load;
    logic        bubble;
    logic        halt_hit;

    assign pc_plus4 = pc_q + 32'd4;

    // Branch and stall are already excluded by the priority chain below.
    assign halt_hit = ifid_valid && (jump_target[31:2] == ifid_pc[31:2]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                bubble  = 1'b1;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d   = word_align(branch_target);
                    bubble = 1'b1;
                end else if (jump && !stall) begin
                    pc_d   = word_align(jump_target);
                    bubble = 1'b1;
                    if (halt_hit) state_d = ST_HALT;
                end else if (stall) begin
                    // hold PC and IF/ID
                end else if (flush) begin
                    pc_d   = pc_plus4;
                    bubble = 1'b1;
                end else begin
                    pc_d = pc_plus4;
                    load = 1'b1;
                end
            end
            ST_HALT: begin
                bubble = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
                bubble  = 1'b1;
            end
        endcase
    end

    assign count_d = count_q + {31'b0, load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .bubble_i (bubble),
        .inst_i   (imem.imem_inst),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .valid_o  (ifid_valid),
        .inst_o   (ifid_inst),
        .pc_o     (ifid_pc),
        .pc4_o    (ifid_pc4)
    );

    assign imem.imem_addr = pc_q;
    assign halted         = (state_q == ST_HALT);
    assign inst_count     = count_q;

endmodule
